handshake_fifo_buffer: RTL and testbench
========================================

// Module: handshake_fifo_buffer
// PURPOSE
//   Elastic FIFO buffer stage placed directly downstream of handshake constant/source units.
//   It decouples producer and consumer timing and breaks the combinational valid/ready chain.
//   Its valid/ready/data channel is identical to every other handshake unit, so it can be
//   inserted on any edge of the dataflow graph.
// PARAMETERS
//   DATA_WIDTH  32  width of the ins/outs data bus
//   DEPTH       4   number of storage slots; legal range 1..64; need not be a power of two
// PORTS
//   clk         input   1           clock; all state updates on the rising edge
//   rst         input   1           synchronous, active-high reset
//   ins         input   DATA_WIDTH  input channel data
//   ins_valid   input   1           input channel valid
//   ins_ready   output  1           input channel ready
//   outs        output  DATA_WIDTH  output channel data (head of FIFO)
//   outs_valid  output  1           output channel valid
//   outs_ready  input   1           output channel ready
// BEHAVIOUR
//   - Transfers: push = ins_valid & ins_ready; pop = outs_valid & outs_ready.
//     Both are evaluated in the same cycle.
//   - State:
//     - storage mem[0..DEPTH-1]
//     - wr_ptr and rd_ptr, each $clog2(DEPTH) bits (minimum 1)
//     - count, $clog2(DEPTH+1) bits
//   - Pointer wrap: each pointer increments on its event and wraps from DEPTH-1 to 0.
//     Explicit compare, not a natural overflow.
//   - count update: count += push - pop. Simultaneous push and pop leave count unchanged.
//   - ins_ready = (count != DEPTH). It is registered-state only and never depends on
//     outs_ready; there is no ready combinational path.
//   - outs_valid = (count != 0); outs = mem[rd_ptr].
//   - Latency: a token accepted in cycle N is first visible on outs in cycle N+1.
//   - Throughput: 1 token/cycle sustained whenever 0 < count < DEPTH.
//   - Full (count == DEPTH): ins_ready = 0. A pop in the same cycle frees a slot for the
//     next cycle only.
//   - Empty (count == 0): outs_valid = 0. outs still shows mem[rd_ptr] (stale data); it is
//     don't-care to the consumer.
//   - Holding: while outs_valid = 1 and outs_ready = 0, outs is stable and does not change.
//   - Ordering: strict FIFO. No token is dropped or duplicated.
//   - Reset (rst = 1 at a clock edge):
//     - wr_ptr = rd_ptr = count = 0; all mem slots = 0.
//     - After reset: outs_valid = 0, ins_ready = 1, outs = 0.
//     - Reset mid-operation discards all stored tokens. Any push or pop presented in the
//       reset cycle is ignored.
// CONFIGURATION
//   HANDSHAKE_FIFO_BUFFER_BYPASS_EN (defined):
//     - When count == 0 and outs_ready = 1, the input passes through combinationally:
//       outs = ins, outs_valid = ins_valid. The token is not written to storage.
//     - outs_valid = (count != 0) | ins_valid. outs = (count != 0) ? mem[rd_ptr] : ins.
//     - Zero latency when empty. When count == 0 and outs_ready = 0, the token is stored
//       as normal.
//   HANDSHAKE_FIFO_BUFFER_BYPASS_EN (undefined):
//     - Fully registered output. Minimum latency is 1 cycle, as described above.
//     - No ins->outs combinational path.
// TESTING  (DATA_WIDTH=32, DEPTH=4 unless noted)
//   1. Reset -> outs_valid=0, ins_ready=1, outs=0.
//      Assert rst=1 mid-stream with 3 tokens held -> next cycle count=0, outs_valid=0.
//   2. Push 0x6 with outs_ready=0 -> cycle+1: outs_valid=1, outs=0x6.
//      Hold 5 cycles -> outs stays 0x6.
//      Then outs_ready=1 -> token consumed, outs_valid=0.
//   3. Fill: push 0x1,0x2,0x3,0x4 with outs_ready=0 -> ins_ready=0 after the 4th push.
//      A 5th push of 0x5 is not accepted.
//      Drain -> outputs 0x1..0x4 in order, then 0x5 once re-presented.
//   4. Full with simultaneous pop: count=4, ins_valid=1, outs_ready=1 -> pop only.
//      Next cycle ins_ready=1 and the push succeeds.
//      Pointers wrap correctly (rd 3->0) with no data corruption.
//   5. Streaming: ins_valid=outs_ready=1 for 20 cycles carrying 0..19 -> outputs 0..19
//      in order, 1 per cycle after the first-token latency.
//      Repeat with random outs_ready backpressure and a scoreboard check.
//   6. BYPASS_EN defined, empty, outs_ready=1, ins=0xA valid -> same cycle outs=0xA,
//      outs_valid=1, and count stays 0.
//      With outs_ready=0 -> token stored, count=1.
//      Also run DEPTH=1 and DEPTH=3 (non-power-of-two wrap).

Source files
------------

// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO stage with registered ready and (by default) registered output.
// Define HANDSHAKE_FIFO_BUFFER_BYPASS_EN for a zero-latency pass-through when the FIFO is empty.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign ins_ready = ~full;
    assign push      = ins_valid & ins_ready;
    assign pop       = outs_valid & outs_ready;

`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
    logic bypass;

    // Empty and consumer ready: the token flows straight through and never touches storage.
    assign bypass     = empty & outs_ready;
    assign outs_valid = ~empty | ins_valid;
    assign outs       = empty ? ins : mem[rd_ptr];
    assign wr_en      = push & ~bypass;
    assign rd_en      = pop & ~empty;
`else
    assign outs_valid = ~empty;
    assign outs       = mem[rd_ptr];
    assign wr_en      = push;
    assign rd_en      = pop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= ins;
                wr_ptr      <= bump(wr_ptr);
            end
            if (rd_en) rd_ptr <= bump(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed bench for handshake_fifo_buffer: DEPTH 4 main instance plus DEPTH 3 and DEPTH 1.
module tb_handshake_fifo_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Lane 0: DEPTH=4, lane 1: DEPTH=3, lane 2: DEPTH=1.
    logic [2:0]       iv, ir, ov, ordy;
    logic [2:0][31:0] id, od;

    int tests = 0;
    int fails = 0;
    int first_pop, last_pop;

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ins(id[0]), .ins_valid(iv[0]), .ins_ready(ir[0]),
        .outs(od[0]), .outs_valid(ov[0]), .outs_ready(ordy[0]));
    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .ins(id[1]), .ins_valid(iv[1]), .ins_ready(ir[1]),
        .outs(od[1]), .outs_valid(ov[1]), .outs_ready(ordy[1]));
    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .ins(id[2]), .ins_valid(iv[2]), .ins_ready(ir[2]),
        .outs(od[2]), .outs_valid(ov[2]), .outs_ready(ordy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // All three lanes stream n tokens base.. against a queue model; pops checked in order.
    task automatic stream(input int n, input int base, input bit rnd, input int budget);
        logic [31:0] q[3][$];
        int sent[3];
        int got[3];
        logic [31:0] exp;
        int c;
        for (int l = 0; l < 3; l++) begin
            sent[l] = 0;
            got[l]  = 0;
        end
        first_pop = -1;
        last_pop  = -1;
        c = 0;
        while (c < budget && !(got[0] == n && got[1] == n && got[2] == n)) begin
            for (int l = 0; l < 3; l++) begin
                iv[l]   = (sent[l] < n) && (!rnd || $urandom_range(0, 1) == 1);
                id[l]   = base + sent[l];
                ordy[l] = !rnd || ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int l = 0; l < 3; l++) begin
                if (iv[l] && ir[l]) begin
                    q[l].push_back(id[l]);
                    sent[l]++;
                end
                if (ov[l] && ordy[l]) begin
                    exp = (q[l].size() > 0) ? q[l].pop_front() : 32'hDEAD_BEEF;
                    check($sformatf("stream_l%0d_tok%0d", l, got[l]), od[l], exp);
                    got[l]++;
                    if (l == 0) begin
                        if (first_pop < 0) first_pop = c;
                        last_pop = c;
                    end
                end
            end
            cyc();
            c++;
        end
        iv   = '0;
        ordy = '0;
        for (int l = 0; l < 3; l++) check($sformatf("stream_l%0d_count", l), got[l], n);
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        id   = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        check("rst_outs_valid", ov[0], 0);
        check("rst_ins_ready", ir[0], 1);
        check("rst_outs", od[0], 0);

        // Single token, 1-cycle latency, then held under backpressure
        id[0] = 32'h6; iv[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        check("lat_outs_valid", ov[0], 1);
        check("lat_outs", od[0], 32'h6);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("hold_%0d", i), od[0], 32'h6);
        end
        check("hold_valid", ov[0], 1);
        ordy[0] = 1'b1;
        cyc();
        ordy[0] = 1'b0;
        check("consumed_valid", ov[0], 0);

        // Fill every lane with 1..4; deeper ones saturate at their own DEPTH
        iv = 3'b111;
        for (int i = 1; i <= 4; i++) begin
            for (int l = 0; l < 3; l++) id[l] = i;
            cyc();
        end
        check("full4_ins_ready", ir[0], 0);
        check("full3_ins_ready", ir[1], 0);
        check("full1_ins_ready", ir[2], 0);
        check("full1_head", od[2], 1);
        iv = 3'b001; id[0] = 32'h5;
        cyc();
        iv = '0;
        check("full_reject", ir[0], 0);
        check("full_head", od[0], 1);
        ordy = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), od[0], k);
            if (k <= 3) check($sformatf("drain3_%0d", k), od[1], k);
            cyc();
        end
        check("drained_valid", ov[0], 0);
        check("drained3_valid", ov[1], 0);
        check("drained1_valid", ov[2], 0);
        ordy = '0;
        id[0] = 32'h5; iv[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        check("represent_5", od[0], 32'h5);
        ordy[0] = 1'b1;
        cyc();
        ordy[0] = 1'b0;
        check("represent_done", ov[0], 0);

        // Full with simultaneous pop: pop only, slot frees next cycle, rd pointer wraps
        iv[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id[0] = 32'h11 + i;
            cyc();
        end
        check("full_again", ir[0], 0);
        id[0] = 32'h15; ordy[0] = 1'b1;
        #1;
        check("fullpop_head", od[0], 32'h11);
        cyc();
        check("fullpop_ready", ir[0], 1);
        check("fullpop_next", od[0], 32'h12);
        ordy[0] = 1'b0;
        cyc();
        iv[0] = 1'b0;
        check("fullpop_refill", ir[0], 0);
        ordy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_%0d", k), od[0], 32'h12 + k);
            cyc();
        end
        ordy[0] = 1'b0;
        check("wrap_empty", ov[0], 0);

        // Full-rate streaming: one token per cycle on lane 0
        stream(20, 0, 1'b0, 200);
        check("stream_rate", last_pop - first_pop, 19);

        // Random backpressure on all depths
        stream(40, 100, 1'b1, 2000);

        // Reset mid-stream with 3 tokens held; push/pop in the reset cycle are ignored
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id[0] = 32'h21 + i;
            cyc();
        end
        check("pre_rst_valid", ov[0], 1);
        rst = 1'b1; id[0] = 32'h99; ordy[0] = 1'b1;
        cyc();
        rst = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
        check("midrst_valid", ov[0], 0);
        check("midrst_ready", ir[0], 1);
        check("midrst_outs", od[0], 0);
        cyc();
        check("midrst_nopush", ov[0], 0);

        // Empty with consumer ready: pass-through only in the bypass build
        id[0] = 32'hA; iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
`ifdef HANDSHAKE_FIFO_BUFFER_BYPASS_EN
        check("byp_outs", od[0], 32'hA);
        check("byp_valid", ov[0], 1);
        cyc();
        iv[0] = 1'b0;
        check("byp_not_stored", ov[0], 0);
`else
        check("nobyp_valid", ov[0], 0);
        cyc();
        iv[0] = 1'b0;
        check("nobyp_outs", od[0], 32'hA);
        cyc();
        check("nobyp_drained", ov[0], 0);
`endif
        ordy[0] = 1'b0; id[0] = 32'hB; iv[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        check("stored_valid", ov[0], 1);
        check("stored_outs", od[0], 32'hB);
        ordy[0] = 1'b1;
        cyc();
        ordy[0] = 1'b0;
        check("stored_drained", ov[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
